// File: rtl/buzzer_scheduler_if.sv
// buzzer_scheduler_if: groups the alarm request lines and the buzzer control
// outputs of the buzzer scheduler.
// master: the alarm/sensor side, which drives req and observes the results.
// slave:  the scheduler itself.
interface buzzer_scheduler_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  logic [2:0]       play_sel;
  logic             play_en;
  logic             busy;
  logic             done;

  modport master (
    output req,
    input  grant,
    input  play_sel,
    input  play_en,
    input  busy,
    input  done
  );

  modport slave (
    input  req,
    output grant,
    output play_sel,
    output play_en,
    output busy,
    output done
  );
endinterface

// File: rtl/buzzer_scheduler.sv
// buzzer_scheduler: shares one piezo buzzer among N_REQ alarm sources.
// The owner gets REPEATS plays of PLAY_CYCLES each. Consecutive plays are
// separated by GAP_CYCLES of silence, so the melody generator restarts from
// idle. A silent COOLDOWN_CYCLES lockout follows the last play. If the owner's
// request drops during a play or gap, the grant ends at once, without a done
// pulse and without a cooldown.
// Optional feature: define BUZZER_SCHED_RR_EN for round-robin arbitration.
// The default build uses fixed priority, where the lowest index wins.
module buzzer_scheduler #(
  parameter int unsigned N_REQ           = 4,
  parameter int unsigned PLAY_CYCLES     = 342_000_000,
  parameter int unsigned GAP_CYCLES      = 2_000_000,
  parameter int unsigned REPEATS         = 2,
  parameter int unsigned COOLDOWN_CYCLES = 1_500_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  buzzer_scheduler_if.slave   bus
);

  localparam logic [31:0] PLAY_LAST = 32'(PLAY_CYCLES - 1);
  localparam logic [31:0] GAP_LAST  = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] COOL_LAST = 32'(COOLDOWN_CYCLES - 1);
  localparam logic [4:0]  REP_LIMIT = 5'(REPEATS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PLAY     = 2'd1,
    GAP      = 2'd2,
    COOLDOWN = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [3:0]       rep_q, rep_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [2:0]       play_sel_q, play_sel_d;
  logic             play_en_q, play_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [2:0]       win_idx;
  logic             owner_req;

`ifdef BUZZER_SCHED_RR_EN
  logic [2:0] rr_ptr_q, rr_ptr_d;
  logic [2:0] lo_idx, hi_idx;
  logic       hi_found;

  // Round-robin winner: lowest requester above the pointer, else wrap to the lowest set bit
  always_comb begin
    lo_idx   = '0;
    hi_idx   = '0;
    hi_found = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        lo_idx = 3'(i);
      end
      if (bus.req[i] && (i > int'(rr_ptr_q))) begin
        hi_idx   = 3'(i);
        hi_found = 1'b1;
      end
    end
    win_idx = hi_found ? hi_idx : lo_idx;
  end

  // The pointer follows each new grant; aborts leave it where it is
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if ((state_q == IDLE) && (|bus.req)) begin
      rr_ptr_d = win_idx;
    end
  end

  // Pointer register, starting just below requester 0 so bit 0 is first in line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= 3'(N_REQ - 1);
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  // Fixed-priority winner: the lowest set request index
  always_comb begin
    win_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        win_idx = 3'(i);
      end
    end
  end
`endif

  assign owner_req = |(bus.req & grant_q);

  // Sequencer: arbitration, the play/gap/repeat/cooldown pattern, and aborts
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rep_d      = rep_q;
    grant_d    = grant_q;
    play_sel_d = play_sel_q;
    play_en_d  = play_en_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d    = PLAY;
          grant_d    = {{(N_REQ - 1){1'b0}}, 1'b1} << win_idx;
          play_sel_d = win_idx;
          play_en_d  = 1'b1;
          busy_d     = 1'b1;
          cnt_d      = '0;
          rep_d      = '0;
        end
      end

      PLAY: begin
        if (!owner_req) begin
          state_d   = IDLE;
          grant_d   = '0;
          play_en_d = 1'b0;
          busy_d    = 1'b0;
          cnt_d     = '0;
        end else if (cnt_q == PLAY_LAST) begin
          cnt_d     = '0;
          rep_d     = rep_q + 4'd1;
          play_en_d = 1'b0;
          if (({1'b0, rep_q} + 5'd1) < REP_LIMIT) begin
            state_d = GAP;
          end else begin
            state_d = COOLDOWN;
            grant_d = '0;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      GAP: begin
        if (!owner_req) begin
          state_d   = IDLE;
          grant_d   = '0;
          play_en_d = 1'b0;
          busy_d    = 1'b0;
          cnt_d     = '0;
        end else if (cnt_q == GAP_LAST) begin
          state_d   = PLAY;
          cnt_d     = '0;
          play_en_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      COOLDOWN: begin
        if (cnt_q == COOL_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      default: begin
        state_d   = IDLE;
        grant_d   = '0;
        play_en_d = 1'b0;
        busy_d    = 1'b0;
        cnt_d     = '0;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rep_q      <= '0;
      grant_q    <= '0;
      play_sel_q <= '0;
      play_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rep_q      <= rep_d;
      grant_q    <= grant_d;
      play_sel_q <= play_sel_d;
      play_en_q  <= play_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.play_sel = play_sel_q;
  assign bus.play_en  = play_en_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_buzzer_scheduler.sv
// tb_buzzer_scheduler: scoreboard bench for buzzer_scheduler.
// dut_a uses PLAY=10, GAP=3, REPEATS=2, COOLDOWN=20.
// dut_b uses PLAY=10, GAP=1, REPEATS=1, COOLDOWN=20.
// The stimulus process pushes the expected grants, play lengths, busy lengths
// and done pulses. The monitor pops each entry as the DUT presents it.
module tb_buzzer_scheduler;

  logic clk = 1'b0;
  logic rst_n_a;
  logic rst_n_b;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  buzzer_scheduler_if #(.N_REQ(4)) bus_a ();
  buzzer_scheduler_if #(.N_REQ(4)) bus_b ();

  buzzer_scheduler #(
    .N_REQ(4), .PLAY_CYCLES(10), .GAP_CYCLES(3), .REPEATS(2), .COOLDOWN_CYCLES(20)
  ) dut_a (
    .clk(clk), .rst_n(rst_n_a), .bus(bus_a)
  );

  buzzer_scheduler #(
    .N_REQ(4), .PLAY_CYCLES(10), .GAP_CYCLES(1), .REPEATS(1), .COOLDOWN_CYCLES(20)
  ) dut_b (
    .clk(clk), .rst_n(rst_n_b), .bus(bus_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         dut;
    logic [3:0] grant;
    logic [2:0] sel;
    int         cyc;
  } grant_exp_t;

  typedef struct {
    int dut;
    int val;
  } run_exp_t;

  grant_exp_t grant_q[$];
  run_exp_t   play_q[$];
  run_exp_t   busy_q[$];
  run_exp_t   done_q[$];

  logic [3:0] m_grant [2];
  logic [2:0] m_sel   [2];
  logic       m_en    [2];
  logic       m_busy  [2];
  logic       m_done  [2];

  assign m_grant[0] = bus_a.grant;
  assign m_sel[0]   = bus_a.play_sel;
  assign m_en[0]    = bus_a.play_en;
  assign m_busy[0]  = bus_a.busy;
  assign m_done[0]  = bus_a.done;
  assign m_grant[1] = bus_b.grant;
  assign m_sel[1]   = bus_b.play_sel;
  assign m_en[1]    = bus_b.play_en;
  assign m_busy[1]  = bus_b.busy;
  assign m_done[1]  = bus_b.done;

  task automatic reportFail(input string name, input int actual, input int expected);
    tests++;
    fails++;
    $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    if (actual !== expected) begin
      reportFail(name, int'(actual), int'(expected));
    end else begin
      tests++;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] req_a, input logic [3:0] req_b);
    bus_a.req = req_a;
    bus_b.req = req_b;
  endtask

  task automatic waitUntil(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic pushGrant(input int d, input logic [3:0] g, input logic [2:0] s, input int c);
    grant_exp_t e;
    e.dut = d; e.grant = g; e.sel = s; e.cyc = c;
    grant_q.push_back(e);
  endtask

  task automatic pushRun(input int kind, input int d, input int v);
    run_exp_t e;
    e.dut = d; e.val = v;
    if (kind == 0) play_q.push_back(e);
    else if (kind == 1) busy_q.push_back(e);
    else done_q.push_back(e);
  endtask

  // A full grant on dut_a starting at cycle g: two 10-cycle plays, 43 busy cycles, done at g+23
  task automatic pushFullA(input int g);
    pushRun(0, 0, 10);
    pushRun(0, 0, 10);
    pushRun(1, 0, 43);
    pushRun(2, 0, g + 23);
  endtask

  // Monitor: compares each DUT output event against the head of its queue
  initial begin
    logic [3:0] prev_grant [2];
    logic       prev_done  [2];
    int         play_run   [2];
    int         busy_run   [2];
    grant_exp_t ge;
    run_exp_t   re;
    for (int d = 0; d < 2; d++) begin
      prev_grant[d] = '0; prev_done[d] = 1'b0; play_run[d] = 0; busy_run[d] = 0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if ((m_grant[d] != 4'b0) && (prev_grant[d] == 4'b0)) begin
          if (grant_q.size() == 0) begin
            reportFail("unexpected_grant", int'(m_grant[d]), 0);
          end else begin
            ge = grant_q.pop_front();
            checkOutput("grant_dut", 32'(d), 32'(ge.dut));
            checkOutput("grant_value", 32'(m_grant[d]), 32'(ge.grant));
            checkOutput("play_sel", 32'(m_sel[d]), 32'(ge.sel));
            checkOutput("grant_cycle", 32'(cyc), 32'(ge.cyc));
          end
        end
        if (m_en[d]) begin
          play_run[d]++;
        end else if (play_run[d] != 0) begin
          if (play_q.size() == 0) begin
            reportFail("unexpected_play", play_run[d], 0);
          end else begin
            re = play_q.pop_front();
            checkOutput("play_dut", 32'(d), 32'(re.dut));
            checkOutput("play_length", 32'(play_run[d]), 32'(re.val));
          end
          play_run[d] = 0;
        end
        if (m_busy[d]) begin
          busy_run[d]++;
        end else if (busy_run[d] != 0) begin
          if (busy_q.size() == 0) begin
            reportFail("unexpected_busy", busy_run[d], 0);
          end else begin
            re = busy_q.pop_front();
            checkOutput("busy_dut", 32'(d), 32'(re.dut));
            checkOutput("busy_length", 32'(busy_run[d]), 32'(re.val));
          end
          busy_run[d] = 0;
        end
        if (m_done[d]) begin
          if (done_q.size() == 0) begin
            reportFail("unexpected_done", cyc, 0);
          end else begin
            re = done_q.pop_front();
            checkOutput("done_dut", 32'(d), 32'(re.dut));
            checkOutput("done_cycle", 32'(cyc), 32'(re.val));
          end
          checkOutput("done_context", 32'({m_grant[d], m_en[d], m_busy[d]}), 32'(6'b000001));
          checkOutput("done_width", 32'(prev_done[d]), 32'd0);
        end
        prev_grant[d] = m_grant[d];
        prev_done[d]  = m_done[d];
      end
    end
  end

  // Directed stimulus; expected events are pushed as each vector is applied
  initial begin
    int g1, g2, g3, g4, g5, g6, g7, g8, gb;
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    applyStimulus(4'b0000, 4'b0000);
    waitUntil(3);
    checkOutput("reset_a", 32'({bus_a.grant, bus_a.play_sel, bus_a.play_en, bus_a.busy, bus_a.done}), 32'd0);
    checkOutput("reset_b", 32'({bus_b.grant, bus_b.play_sel, bus_b.play_en, bus_b.busy, bus_b.done}), 32'd0);
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    waitUntil(5);
    checkOutput("idle_no_req", 32'({bus_a.grant, bus_a.play_en, bus_a.busy}), 32'd0);

    // req=0001 held: two full rounds, the second re-grant one IDLE cycle after cooldown
    g1 = cyc + 1;
    applyStimulus(4'b0001, 4'b0000);
    pushGrant(0, 4'b0001, 3'd0, g1);
    pushFullA(g1);
    g2 = g1 + 44;
    pushGrant(0, 4'b0001, 3'd0, g2);

    // Drop bit 0 after five play cycles and raise bit 3 at the same time
    waitUntil(g2 + 4);
    applyStimulus(4'b1000, 4'b0000);
    pushRun(0, 0, 5);
    pushRun(1, 0, 5);
    g3 = g2 + 6;
    pushGrant(0, 4'b1000, 3'd3, g3);
    pushFullA(g3);
    waitUntil(g2 + 5);
    checkOutput("abort_grant", 32'(bus_a.grant), 32'd0);
    checkOutput("abort_play_en", 32'(bus_a.play_en), 32'd0);
    checkOutput("abort_done", 32'(bus_a.done), 32'd0);

    // Release during cooldown, then request only while still in cooldown
    waitUntil(g3 + 23);
    applyStimulus(4'b0000, 4'b0000);
    waitUntil(g3 + 30);
    applyStimulus(4'b1000, 4'b0000);
    g4 = g3 + 44;
    pushGrant(0, 4'b1000, 3'd3, g4);
    pushRun(0, 0, 10);
    pushRun(1, 0, 12);

    // Asynchronous reset in the middle of the gap
    waitUntil(g4 + 11);
    #2 rst_n_a = 1'b0;
    #1;
    checkOutput("async_reset_grant", 32'(bus_a.grant), 32'd0);
    checkOutput("async_reset_sel", 32'(bus_a.play_sel), 32'd0);
    checkOutput("async_reset_flags", 32'({bus_a.play_en, bus_a.busy, bus_a.done}), 32'd0);
    waitUntil(g4 + 13);
    applyStimulus(4'b0100, 4'b0000);
    #2 rst_n_a = 1'b1;
    g5 = g4 + 14;
    pushGrant(0, 4'b0100, 3'd2, g5);
    pushFullA(g5);

    // Two simultaneous requesters held across several rounds
    waitUntil(g5 + 2);
    applyStimulus(4'b0110, 4'b0000);
    g6 = g5 + 44;
    g7 = g6 + 44;
    g8 = g7 + 44;
    pushGrant(0, 4'b0010, 3'd1, g6);
    pushFullA(g6);
`ifdef BUZZER_SCHED_RR_EN
    pushGrant(0, 4'b0100, 3'd2, g7);
`else
    pushGrant(0, 4'b0010, 3'd1, g7);
`endif
    pushFullA(g7);
    pushGrant(0, 4'b0010, 3'd1, g8);
    pushFullA(g8);
    waitUntil(g8 + 25);
    applyStimulus(4'b0000, 4'b0000);
    waitUntil(g8 + 50);

    // Single-repeat instance: one play, done right after it, no gap
    gb = cyc + 1;
    applyStimulus(4'b0000, 4'b0001);
    pushGrant(1, 4'b0001, 3'd0, gb);
    pushRun(0, 1, 10);
    pushRun(1, 1, 30);
    pushRun(2, 1, gb + 10);
    waitUntil(gb + 15);
    applyStimulus(4'b0000, 4'b0000);
    waitUntil(gb + 40);

    checkOutput("grants_outstanding", 32'(grant_q.size()), 32'd0);
    checkOutput("plays_outstanding", 32'(play_q.size()), 32'd0);
    checkOutput("busy_outstanding", 32'(busy_q.size()), 32'd0);
    checkOutput("done_outstanding", 32'(done_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
